// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first through one full_adder with a registered carry.
// Operands load on an accepted start; sum/cout update only on the cycle done pulses.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, s_sr_q, s_sr_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic             fa_s, fa_c;

    full_adder u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .ci(c_q), .s(fa_s), .co(fa_c));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                a_sr_d  = a;
                b_sr_d  = b;
                c_d     = cin;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                // new sum bit enters at the MSB so the LSB-first result lands aligned
                s_sr_d = WIDTH'({fa_s, s_sr_q} >> 1);
                c_d    = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = s_sr_d;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus multi-cycle corner sequences and random runs for WIDTH=8 and WIDTH=1.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst, start, cin, busy, done, cout;
    logic [7:0] a, b, sum;
    logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
                                  .busy(busy), .done(done), .sum(sum), .cout(cout));
    serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
                                  .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // one WIDTH=8 operation; junk re-pulses start with a=8'h11 through SHIFT and DONE
    task automatic do8(input string nm, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input bit junk);
        logic [7:0] ps, rs;
        logic       pc, rc;
        int         lat, bcnt, dcnt;
        bit         held;
        ps = sum; pc = cout; rs = sum; rc = cout;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        lat = -1; bcnt = 0; dcnt = 0; held = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = n;
                rs = sum; rc = cout;
            end else if (dcnt == 0 && (sum !== ps || cout !== pc)) held = 1'b0;
            start = junk && n <= 8;
            a = junk ? 8'h11 : 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
        end
        chk({nm, " sum"}, rs, es);
        chk({nm, " cout"}, rc, ec);
        chk({nm, " latency"}, lat, 8);
        chk({nm, " busy_cycles"}, bcnt, 9);
        chk({nm, " done_count"}, dcnt, 1);
        chk({nm, " held"}, held, 1);
    endtask

    task automatic do1(input logic ta, input logic tb, input logic tc);
        int  lat, bcnt;
        logic [1:0] r;
        r = 2'bxx;
        a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = -1; bcnt = 0;
        for (int n = 0; n < 4; n++) begin
            if (busy1) bcnt++;
            if (done1 && lat < 0) begin lat = n; r = {cout1, sum1}; end
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("w1 result", r, 2'(ta) + 2'(tb) + 2'(tc));
        chk("w1 latency", lat, 1);
        chk("w1 busy_cycles", bcnt, 2);
    endtask

    initial begin
        int         dn[$];
        logic [8:0] e;
        logic [7:0] ra, rb;
        logic       rc;
        int         dc;
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vt[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        rst = 1'b1; start = 0; a = 0; b = 0; cin = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset w1", {busy1, done1, sum1, cout1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            do8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].c, 1'b0);

        do8("restart_ignored", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);

        // async reset in the middle of an op, between edges
        a = 8'h77; b = 8'h01; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst sum", sum, 0);
        chk("midrst cout", cout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dc = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        chk("midrst no_done", dc, 0);
        do8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // start held high: back-to-back ops every WIDTH+2 cycles
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dn.push_back(n);
                chk("held_start sum", sum, 8'h03);
            end
        end
        start = 1'b0;
        chk("held_start done_count", dn.size(), 4);
        for (int i = 1; i < dn.size(); i++) chk("held_start interval", dn[i] - dn[i-1], 10);
        repeat (12) @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e = 9'(ra) + 9'(rb) + 9'(rc);
            do8("rand8", ra, rb, rc, e[7:0], e[8], 1'b0);
        end
        for (int i = 0; i < 1000; i++) do1(1'($urandom), 1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
